seq_chunk_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor. Operands are processed CHUNK bits per clock, least-significant chunk first, with the carry registered between chunks. This trades latency for a short critical path on wide operands. It sits in the arithmetic library as the sequential successor to the fixed-width combinational ripple adders, with a start/busy/done handshake, a subtract mode and a signed-overflow flag.

---
 rtl/arith_pkg.sv | 15 +
 rtl/chunk_adder.sv | 25 ++
 rtl/seq_chunk_adder.sv | 118 +++++++++++
 tb/tb_seq_chunk_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM encoding and sizing helper for the sequential adders
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational W-bit ripple of full adders with carry into the MSB
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
  end

  assign co    = w_c[W];
  assign c_msb = w_c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked ripple adder/subtractor with start/busy/done
module seq_chunk_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam int TOP    = WIDTH - CHUNK;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_shadow_nxt;

  // Operands shift down one chunk per cycle so the adder always sees bits [CHUNK-1:0].
  chunk_adder #(.W(CHUNK)) u_chunk (
    .x     (r_a[CHUNK-1:0]),
    .y     (r_b[CHUNK-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  assign w_last       = (r_idx == LAST_IDX);
  assign w_accept     = start && ((r_state == IDLE) || (r_state == DONE));
  // Each new chunk enters at the top; after NCHUNK steps chunk 0 lands at the bottom.
  assign w_shadow_nxt = (r_shadow >> CHUNK) | (WIDTH'(w_s) << TOP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_sum    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> CHUNK;
      r_b      <= r_b >> CHUNK;
      r_shadow <= w_shadow_nxt;
      r_carry  <= w_co;
      if (w_last) begin
        r_sum  <= w_shadow_nxt;
        r_cout <= w_co;
        r_ovf  <= w_cmsb ^ w_co;
      end else begin
        r_idx <= r_idx + CW'(1);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        s_start = 1'b0;
  logic        s_sub = 1'b0;
  logic        s_cin = 1'b0;
  logic [7:0]  s_a = '0;
  logic [7:0]  s_b = '0;
  logic [2:0]  sw_busy, sw_done, sw_cout, sw_ovf;
  logic [2:0][7:0] sw_sum;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(sw_busy[0]), .done(sw_done[0]), .sum(sw_sum[0]), .cout(sw_cout[0]), .ovf(sw_ovf[0]));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(sw_busy[1]), .done(sw_done[1]), .sum(sw_sum[1]), .cout(sw_cout[1]), .ovf(sw_ovf[1]));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(sw_busy[2]), .done(sw_done[2]), .sum(sw_sum[2]), .cout(sw_cout[2]), .ovf(sw_ovf[2]));

  // Reference results {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    int sx, sy, t;
    logic [16:0] full;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      full = {1'b0, x} + 17'h10000 - {1'b0, y};
      t = sx - sy;
    end else begin
      full = {1'b0, x} + {1'b0, y} + 17'(ci);
      t = sx + sy + int'(ci);
    end
    return {(t > 32767 || t < -32768), full};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                      input logic ci, input logic sb);
    int sx, sy, t;
    logic [8:0] full;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      full = {1'b0, x} + 9'h100 - {1'b0, y};
      t = sx - sy;
    end else begin
      full = {1'b0, x} + {1'b0, y} + 9'(ci);
      t = sx + sy + int'(ci);
    end
    return {(t > 127 || t < -128), full};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model of the 16-bit instance: an accepted op occupies N cycles.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_sum = '0;
  logic        m_cout = 1'b0;
  logic        m_ovf = 1'b0;
  logic [17:0] m_pend = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_sum  <= m_pend[15:0];
        m_cout <= m_pend[16];
        m_ovf  <= m_pend[17];
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref16(a, b, cin, sub);
        m_left <= N;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_left > 0) || done !== m_done || sum !== m_sum ||
          cout !== m_cout || ovf !== m_ovf) begin
        errors++;
        $display("FAIL cycle_compare @%0t: busy=%b done=%b sum=%h cout=%b ovf=%b expected busy=%b done=%b sum=%h cout=%b ovf=%b",
                 $time, busy, done, sum, cout, ovf, (m_left > 0), m_done, m_sum, m_cout, m_ovf);
      end
    end
  end

  task automatic go(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
  endtask

  task automatic wait_done(input string nm, input logic [15:0] es, input logic ec,
                           input logic eo, input bit inject);
    int lat, nbusy;
    lat = 0;
    nbusy = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = ~cin;
        sub = ~sub;
      end
      if (inject && k == 2) start = 1'b1;
      if (inject && k == 3) start = 1'b0;
      if (busy) nbusy++;
      if (done) lat = k;
    end
    chk({nm, "_latency"}, lat, N + 1);
    chk({nm, "_busy_cycles"}, nbusy, N);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
  endtask

  int vals[16] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'hFE,
                   8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h40, 8'hC0, 8'h3C, 8'h7E};
  int nch[3] = '{8, 4, 1};

  initial begin
    chk("model_pin_carry", 32'(ref16(16'h0001, 16'hFFFF, 1'b0, 1'b0)), 32'h10000);
    chk("model_pin_sub", 32'(ref16(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk_en = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);

    go(16'h0001, 16'hFFFF, 1'b0, 1'b0); wait_done("carry_all", 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    go(16'h7FFF, 16'h0000, 1'b1, 1'b0); wait_done("ovf_cin", 16'h8000, 1'b0, 1'b1, 1'b0);
    go(16'h1234, 16'h4321, 1'b0, 1'b0); wait_done("add_5555", 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    go(16'h0005, 16'h0009, 1'b0, 1'b1); wait_done("sub_neg", 16'hFFFC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    go(16'h8000, 16'h0001, 1'b0, 1'b1); wait_done("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    go(16'h0005, 16'h0009, 1'b1, 1'b1); wait_done("sub_cin_ign", 16'hFFFC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    go(16'h1111, 16'h2222, 1'b0, 1'b0); wait_done("mid_start", 16'h3333, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    go(16'h000A, 16'h0003, 1'b0, 1'b1); wait_done("b2b_first", 16'h0007, 1'b1, 1'b0, 1'b0);
    go(16'hFFFF, 16'h0001, 1'b1, 1'b0); wait_done("b2b_second", 16'h0001, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    go(16'h00FF, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_done", done, 0);
    chk("rst_run_sum", sum, 0);
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("rst_run_no_done", seen, 0);
    end

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int m = 0; m < 4; m++) begin
          int lat[3];
          logic [9:0] got[3];
          logic [9:0] exp;
          s_a = 8'(vals[ia]);
          s_b = 8'(vals[ib]);
          s_cin = m[0];
          s_sub = m[1];
          s_start = 1'b1;
          exp = ref8(s_a, s_b, s_cin, s_sub);
          lat = '{0, 0, 0};
          got = '{10'h0, 10'h0, 10'h0};
          for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) s_start = 1'b0;
            for (int j = 0; j < 3; j++) begin
              if (sw_done[j] && lat[j] == 0) begin
                lat[j] = k;
                got[j] = {sw_ovf[j], sw_cout[j], sw_sum[j]};
              end
            end
          end
          for (int j = 0; j < 3; j++) begin
            chk($sformatf("sweep_c%0d_%h_%h_m%0d_result", 8 / nch[j], s_a, s_b, m), 32'(got[j]), 32'(exp));
            chk($sformatf("sweep_c%0d_latency", 8 / nch[j]), lat[j], nch[j] + 1);
          end
        end
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
